alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Sequences the combinational ALU_J datapath from a command stream. It holds a small
//  register file and accepts {opcode, src1, src2, dst, param} commands over a valid/ready
//  handshake. For each command it drives the ALU, captures result/status, writes the result
//  back to the register file and updates a sticky flag register. It sits between the
//  instruction front-end and ALU_J.
// PARAMETERS
//  DataWidth      8   ALU operand/result width; register file word width
//  NumOpCodeBits  5   opcode width (Op_NOP=0 .. Op_VAL=8)
//  ParamBits      8   param width passed to the ALU
//  NumStatusBits  3   ALU status width: [0]=overflow/carry, [1]=ALU-defined, [2]=zero
//  NumRegs        4   register file depth; RegAddrBits = $clog2(NumRegs) = 2
// PORTS
//  clk           in   1              single clock, all state on rising edge
//  rst           in   1              synchronous, active-high reset
//  cmd_valid     in   1              command present
//  cmd_ready     out  1              sequencer accepts a command this cycle
//  cmd_opcode    in   NumOpCodeBits  ALU operation
//  cmd_src1      in   RegAddrBits    register index for operand1
//  cmd_src2      in   RegAddrBits    register index for operand2
//  cmd_dst       in   RegAddrBits    destination register index
//  cmd_param     in   ParamBits      immediate, forwarded to the ALU param input
//  alu_opcode    out  NumOpCodeBits  to ALU_J.opcode
//  alu_operand1  out  DataWidth      to ALU_J.operand1
//  alu_operand2  out  DataWidth      to ALU_J.operand2
//  alu_param     out  ParamBits      to ALU_J.param
//  alu_result    in   DataWidth      from ALU_J.result (combinational)
//  alu_status    in   NumStatusBits  from ALU_J.status (combinational)
//  done          out  1              one-cycle pulse: command retired
//  flags         out  NumStatusBits  status of the last retired non-NOP command
//  rd_addr       in   RegAddrBits    debug/readout register index
//  rd_data       out  DataWidth      combinational read of regs[rd_addr]
// BEHAVIOUR
//  - Reset: state=IDLE; all regs=0; flags=0; done=0; cmd_ready=1; alu_* outputs=0 (NOP).
//  - FSM states:
//      IDLE  cmd_ready=1. On cmd_valid: latch the command and go to LOAD.
//      LOAD  operand1=regs[src1] and operand2=regs[src2] latch into operand regs. Go to EXEC.
//      EXEC  alu_* driven from latched values. alu_result/alu_status sampled into a
//            capture register at the end of the cycle. Go to WB.
//      WB    regs[dst] <= captured result and flags <= captured status, except for
//            NOP/illegal. done=1. Go to IDLE.
//  - cmd_ready=1 only in IDLE, so there is no back-to-back acceptance.
//  - Latency: handshake at edge T means done is high in the cycle after edge T+3.
//    Throughput is 1 command per 4 cycles.
//  - alu_* outputs hold the latched command through LOAD/EXEC/WB. They are 0 in IDLE.
//  - Op_NOP: goes through all states and pulses done. No regfile write; flags unchanged.
//  - Opcodes > Op_VAL are illegal. They are driven to the ALU as Op_NOP and handled as NOP.
//  - src1 == src2 == dst is legal. Operands are read in LOAD, before the WB write.
//  - rd_data reflects a writeback on the cycle after the WB edge.
//  - cmd_* inputs are ignored outside the IDLE handshake cycle. Changes mid-operation have
//    no effect.
//  - rst asserted in any state aborts the command: no writeback, no done, and all state
//    returns to reset values on that edge.
//  - Arithmetic is entirely in ALU_J. Results are DataWidth bits and wrap; overflow is
//    reported only via status[0].
// TESTING
//  1. rst 2 cycles -> cmd_ready=1, done=0, flags=0, rd_data=0 for all rd_addr.
//  2. VAL dst=0 param=255, then VAL dst=1 param=2, then ADD src1=0 src2=1 dst=2
//     -> r2=1, flags[0]=1; done exactly 4 cycles after each accept.
//  3. VAL r0=8'hCC, VAL r1=8'h33, AND 0,1->3 -> r3=0, flags=3'b100;
//     then OR 0,1->3 -> r3=8'hFF, flags=0.
//  4. NOP, and opcode 5'h1F, after case 3 -> done pulses, alu_opcode=0, regs and flags
//     unchanged.
//  5. Hold cmd_valid=1 with changing cmd_* during a command -> only the IDLE-cycle
//     command executes; cmd_ready=0 for 3 cycles.
//  6. Assert rst in EXEC of ADD into r2 (r2=8'h11 before) -> no done, r2=0 (reset),
//     flags=0, back to IDLE.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the ALU_J datapath. Each accepted command takes four cycles:
// IDLE (accept) -> LOAD (read operands) -> EXEC (drive ALU, capture) -> WB (write back).
module alu_cmd_sequencer #(
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned NumOpCodeBits = 5,
  parameter int unsigned ParamBits     = 8,
  parameter int unsigned NumStatusBits = 3,
  parameter int unsigned NumRegs       = 4,
  localparam int unsigned RegAddrBits  = $clog2(NumRegs)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [NumOpCodeBits-1:0] cmd_opcode_i,
  input  logic [RegAddrBits-1:0]   cmd_src1_i,
  input  logic [RegAddrBits-1:0]   cmd_src2_i,
  input  logic [RegAddrBits-1:0]   cmd_dst_i,
  input  logic [ParamBits-1:0]     cmd_param_i,
  output logic [NumOpCodeBits-1:0] alu_opcode_o,
  output logic [DataWidth-1:0]     alu_operand1_o,
  output logic [DataWidth-1:0]     alu_operand2_o,
  output logic [ParamBits-1:0]     alu_param_o,
  input  logic [DataWidth-1:0]     alu_result_i,
  input  logic [NumStatusBits-1:0] alu_status_i,
  output logic                     done_o,
  output logic [NumStatusBits-1:0] flags_o,
  input  logic [RegAddrBits-1:0]   rd_addr_i,
  output logic [DataWidth-1:0]     rd_data_o
);

  localparam logic [NumOpCodeBits-1:0] OpNop = '0;
  localparam logic [NumOpCodeBits-1:0] OpVal = NumOpCodeBits'(8);

  typedef enum logic [1:0] {StIdle, StLoad, StExec, StWb} state_e;

  state_e state_q, state_d;

  logic [NumOpCodeBits-1:0] op_q;
  logic [RegAddrBits-1:0]   src1_q, src2_q, dst_q;
  logic [ParamBits-1:0]     param_q;
  logic [DataWidth-1:0]     opnd1_q, opnd2_q;
  logic [DataWidth-1:0]     res_q;
  logic [NumStatusBits-1:0] stat_q;
  logic [NumStatusBits-1:0] flags_q;
  logic [DataWidth-1:0]     regs_q [NumRegs];
  logic                     done_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed four-cycle walk once a command is accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_valid_i) state_d = StLoad;
      StLoad:  state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: command latch, operand fetch, result capture, write-back and done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q    <= OpNop;
      src1_q  <= '0;
      src2_q  <= '0;
      dst_q   <= '0;
      param_q <= '0;
      opnd1_q <= '0;
      opnd2_q <= '0;
      res_q   <= '0;
      stat_q  <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      // done is registered so it appears in the cycle after the write-back edge.
      done_q <= (state_q == StWb);
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            // Illegal opcodes are folded to NOP at accept time.
            op_q    <= (cmd_opcode_i > OpVal) ? OpNop : cmd_opcode_i;
            src1_q  <= cmd_src1_i;
            src2_q  <= cmd_src2_i;
            dst_q   <= cmd_dst_i;
            param_q <= cmd_param_i;
          end
        end
        StLoad: begin
          opnd1_q <= regs_q[src1_q];
          opnd2_q <= regs_q[src2_q];
        end
        StExec: begin
          res_q  <= alu_result_i;
          stat_q <= alu_status_i;
        end
        StWb: begin
          if (op_q != OpNop) begin
            regs_q[dst_q] <= res_q;
            flags_q       <= stat_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs: ALU is fed only while a command is in flight; operands become valid after LOAD.
  always_comb begin
    cmd_ready_o    = (state_q == StIdle);
    alu_opcode_o   = '0;
    alu_param_o    = '0;
    alu_operand1_o = '0;
    alu_operand2_o = '0;
    if (state_q != StIdle) begin
      alu_opcode_o = op_q;
      alu_param_o  = param_q;
    end
    if (state_q == StExec || state_q == StWb) begin
      alu_operand1_o = opnd1_q;
      alu_operand2_o = opnd2_q;
    end
    done_o    = done_q;
    flags_o   = flags_q;
    rd_data_o = regs_q[rd_addr_i];
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a stand-in ALU, directed vector table, hand-written
// corner sequences and random commands checked against a register-file model.
module tb_alu_cmd_sequencer;

  localparam logic [4:0] OpNop = 5'd0, OpAdd = 5'd1, OpSub = 5'd2, OpAnd = 5'd3, OpOr = 5'd4;
  localparam logic [4:0] OpVal = 5'd8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_opcode;
  logic [1:0] cmd_src1, cmd_src2, cmd_dst;
  logic [7:0] cmd_param;
  logic [4:0] alu_opcode;
  logic [7:0] alu_operand1, alu_operand2, alu_param, alu_result;
  logic [2:0] alu_status;
  logic       done;
  logic [2:0] flags;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;

  int n_checks = 0;
  int n_err    = 0;

  // Reference state: register file contents and sticky flags.
  logic [7:0] mregs [4];
  logic [2:0] mflags;

  always #5 clk = ~clk;

  // Stand-in ALU: status = {zero, sub-negative, carry/borrow}.
  function automatic logic [10:0] alu_fn(input logic [4:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] p);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, s1;
    r  = 8'h00;
    c  = 1'b0;
    s1 = 1'b0;
    w  = 9'h000;
    case (op)
      5'd1: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; end
      5'd2: begin r = a - b; c = (a < b); s1 = r[7]; end
      5'd3: r = a & b;
      5'd4: r = a | b;
      5'd5: r = a ^ b;
      5'd6: begin r = {a[6:0], 1'b0}; c = a[7]; end
      5'd7: begin r = {1'b0, a[7:1]}; c = a[0]; end
      5'd8: r = p;
      default: r = 8'h00;
    endcase
    return {(r == 8'h00), s1, c, r};
  endfunction

  assign {alu_status, alu_result} = alu_fn(alu_opcode, alu_operand1, alu_operand2, alu_param);

  alu_cmd_sequencer dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_opcode_i   (cmd_opcode),
    .cmd_src1_i     (cmd_src1),
    .cmd_src2_i     (cmd_src2),
    .cmd_dst_i      (cmd_dst),
    .cmd_param_i    (cmd_param),
    .alu_opcode_o   (alu_opcode),
    .alu_operand1_o (alu_operand1),
    .alu_operand2_o (alu_operand2),
    .alu_param_o    (alu_param),
    .alu_result_i   (alu_result),
    .alu_status_i   (alu_status),
    .done_o         (done),
    .flags_o        (flags),
    .rd_addr_i      (rd_addr),
    .rd_data_o      (rd_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_regs(input string name);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      chk(name, rd_data, mregs[i]);
    end
  endtask

  // Issue one command and follow it to retirement. With noise set, cmd_valid stays high and
  // the cmd_* fields churn while the command is in flight.
  task automatic run_cmd(input logic [4:0] op, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [1:0] d, input logic [7:0] p, input bit noise);
    logic [4:0]  eop;
    logic [7:0]  e1, e2;
    logic [10:0] r;
    chk("ready_idle", cmd_ready, 1);
    e1  = mregs[s1];
    e2  = mregs[s2];
    eop = (op > OpVal) ? OpNop : op;
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_src1   = s1;
    cmd_src2   = s2;
    cmd_dst    = d;
    cmd_param  = p;
    step();
    if (!noise) cmd_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("ready_busy", cmd_ready, 0);
      chk("done_early", done, 0);
      chk("alu_opcode", alu_opcode, eop);
      chk("alu_param", alu_param, p);
      if (i == 2) begin
        chk("alu_operand1", alu_operand1, e1);
        chk("alu_operand2", alu_operand2, e2);
      end
      if (noise) begin
        cmd_opcode = 5'($urandom);
        cmd_src1   = 2'($urandom);
        cmd_src2   = 2'($urandom);
        cmd_dst    = 2'($urandom);
        cmd_param  = 8'($urandom);
      end
      step();
    end
    cmd_valid = 1'b0;
    chk("done_pulse", done, 1);
    chk("ready_after", cmd_ready, 1);
    chk("alu_opcode_idle", alu_opcode, 0);
    if (eop != OpNop) begin
      r         = alu_fn(eop, e1, e2, p);
      mregs[d]  = r[7:0];
      mflags    = r[10:8];
    end
    chk("flags", flags, mflags);
    rd_addr = d;
    #1;
    chk("rd_data_dst", rd_data, mregs[d]);
    step();
    chk("done_one_cycle", done, 0);
  endtask

  typedef struct {
    logic [4:0] op;
    logic [1:0] s1, s2, d;
    logic [7:0] p;
    logic [7:0] exp_val;
    logic [2:0] exp_flags;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] op;
    vecs[0] = '{OpVal, 2'd0, 2'd0, 2'd0, 8'hFF, 8'hFF, 3'b000};
    vecs[1] = '{OpVal, 2'd0, 2'd0, 2'd1, 8'h02, 8'h02, 3'b000};
    vecs[2] = '{OpAdd, 2'd0, 2'd1, 2'd2, 8'h00, 8'h01, 3'b001};
    vecs[3] = '{OpVal, 2'd0, 2'd0, 2'd0, 8'hCC, 8'hCC, 3'b000};
    vecs[4] = '{OpVal, 2'd0, 2'd0, 2'd1, 8'h33, 8'h33, 3'b000};
    vecs[5] = '{OpAnd, 2'd0, 2'd1, 2'd3, 8'h00, 8'h00, 3'b100};
    vecs[6] = '{OpNop, 2'd0, 2'd1, 2'd3, 8'h00, 8'h00, 3'b100};
    vecs[7] = '{5'h1F, 2'd0, 2'd1, 2'd3, 8'h77, 8'h00, 3'b100};
    vecs[8] = '{OpOr,  2'd0, 2'd1, 2'd3, 8'h00, 8'hFF, 3'b000};
    vecs[9] = '{OpNop, 2'd0, 2'd1, 2'd3, 8'h00, 8'hFF, 3'b000};

    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
    mflags     = 3'b000;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_opcode = 5'd0;
    cmd_src1   = 2'd0;
    cmd_src2   = 2'd0;
    cmd_dst    = 2'd0;
    cmd_param  = 8'd0;
    rd_addr    = 2'd0;
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_flags", flags, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    check_all_regs("rst_regs");

    // Directed vector table.
    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].d, vecs[i].p, 1'b0);
      rd_addr = vecs[i].d;
      #1;
      chk("vec_value", rd_data, vecs[i].exp_val);
      chk("vec_flags", flags, vecs[i].exp_flags);
    end

    // cmd_* churn during an in-flight command must not disturb it.
    run_cmd(OpVal, 2'd0, 2'd0, 2'd2, 8'h5A, 1'b1);
    rd_addr = 2'd2;
    #1;
    chk("noise_value", rd_data, 8'h5A);
    check_all_regs("noise_regs");

    // Same register as both sources and destination.
    run_cmd(OpAdd, 2'd2, 2'd2, 2'd2, 8'h00, 1'b0);
    rd_addr = 2'd2;
    #1;
    chk("alias_value", rd_data, 8'hB4);

    // Reset while an ADD into r2 is in EXEC aborts it.
    run_cmd(OpVal, 2'd0, 2'd0, 2'd2, 8'h11, 1'b0);
    cmd_valid  = 1'b1;
    cmd_opcode = OpAdd;
    cmd_src1   = 2'd0;
    cmd_src2   = 2'd1;
    cmd_dst    = 2'd2;
    step();
    cmd_valid = 1'b0;
    step();
    chk("abort_in_exec", alu_opcode, OpAdd);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
    mflags = 3'b000;
    chk("abort_done", done, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_flags", flags, 0);
    chk("abort_alu_opcode", alu_opcode, 0);
    check_all_regs("abort_regs");
    step();
    chk("abort_no_late_done", done, 0);

    // Random commands, including SUB and illegal opcodes.
    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 12));
      if (op == 5'd12) op = 5'($urandom_range(9, 31));
      if (op == 5'd11) op = OpSub;
      run_cmd(op, 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom), n[0]);
    end
    check_all_regs("final_regs");
    chk("final_flags", flags, mflags);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
